// File: rtl/icache_axi_rd_bridge.sv
// Instruction-cache refill bridge: turns one line-refill request into a single AXI4 INCR
// read burst, streams beats back to the cache, drains on flush and flags malformed bursts.
module icache_axi_rd_bridge #(
    parameter int         LINE_WORDS = 8,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_addr,
    input  logic        req_valid,
    output logic        req_ready,
    output logic [31:0] resp_data,
    output logic        resp_valid,
    output logic        resp_last,
    input  logic        resp_ready,
    input  logic        abort,
    output logic        busy,
    output logic        err,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam int                 BEAT_W    = $clog2(LINE_WORDS);
    localparam logic [31:0]        OFF_MASK  = 32'((LINE_WORDS * 4) - 1);
    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic                arvalid_q, arvalid_d;
    logic [31:0]         araddr_q, araddr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                err_q, err_d;
    logic                abort_pend_q, abort_pend_d;

    logic req_fire;
    logic ar_fire;
    logic r_fire;
    logic beat_bad;
    logic at_last;

    assign arid    = AXI_ID;
    assign arlen   = 8'(LINE_WORDS - 1);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arvalid = arvalid_q;
    assign araddr  = araddr_q;
    assign err     = err_q;
    assign busy    = (state_q != S_IDLE);

    assign req_ready = (state_q == S_IDLE) && !abort;
    assign req_fire  = req_valid && req_ready;
    assign ar_fire   = arvalid_q && arready;

    // DATA passes the R channel straight through; DRAIN swallows beats unconditionally.
    assign rready = (state_q == S_DRAIN) || ((state_q == S_DATA) && resp_ready);
    assign r_fire = rvalid && rready;

    assign at_last    = (beat_q == LAST_BEAT);
    assign resp_data  = rdata;
    assign resp_valid = (state_q == S_DATA) && rvalid && !abort;
    assign resp_last  = resp_valid && at_last;

    assign beat_bad = (rresp != 2'b00) || (rid != AXI_ID) || (rlast != at_last);

    always_comb begin
        state_d      = state_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        beat_d       = beat_q;
        err_d        = err_q;
        abort_pend_d = abort_pend_q;

        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    state_d      = S_ADDR;
                    araddr_d     = req_addr & ~OFF_MASK;
                    arvalid_d    = 1'b1;
                    beat_d       = '0;
                    err_d        = 1'b0;
                    abort_pend_d = 1'b0;
                end
            end
            S_ADDR: begin
                // AR stays up until accepted; a flush here is remembered and applied afterwards.
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (ar_fire) begin
                    arvalid_d = 1'b0;
                    state_d   = (abort_pend_q || abort) ? S_DRAIN : S_DATA;
                end
            end
            S_DATA: begin
                if (r_fire && rlast) begin
                    state_d = S_IDLE;
                end else if (abort) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_fire && rlast) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (r_fire) begin
            beat_d = beat_q + 1'b1;
            if (beat_bad) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            beat_q       <= '0;
            err_q        <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            beat_q       <= beat_d;
            err_q        <= err_d;
            abort_pend_q <= abort_pend_d;
        end
    end

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed bench for icache_axi_rd_bridge: each task drives one scenario and checks
// the bridge's outputs against hand-computed values.
module tb_icache_axi_rd_bridge;

    logic        clk;
    logic        rst;
    logic [31:0] req_addr;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] resp_data;
    logic        resp_valid;
    logic        resp_last;
    logic        resp_ready;
    logic        abort;
    logic        busy;
    logic        err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int total = 0;
    int bad   = 0;

    icache_axi_rd_bridge #(.LINE_WORDS(8), .AXI_ID(4'd0)) dut (
        .clk(clk), .rst(rst),
        .req_addr(req_addr), .req_valid(req_valid), .req_ready(req_ready),
        .resp_data(resp_data), .resp_valid(resp_valid), .resp_last(resp_last),
        .resp_ready(resp_ready), .abort(abort), .busy(busy), .err(err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic last, input logic [1:0] rs);
        rvalid = 1'b1;
        rdata  = d;
        rlast  = last;
        rresp  = rs;
        rid    = 4'd0;
    endtask

    task automatic stop_beats();
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    task automatic start_burst(input logic [31:0] a, input int dly);
        req_addr  = a;
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        repeat (dly) cyc();
        arready = 1'b1;
        cyc();
        arready = 1'b0;
    endtask

    task automatic good_beats(input int from);
        for (int i = from; i < 8; i++) begin
            drive_beat(32'h9000_0000 + i, (i == 7), 2'b00);
            cyc();
        end
        stop_beats();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        #1;
        total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid got=%b exp=0", arvalid); end
        total++; if (araddr !== 32'h0) begin bad++; $display("FAIL reset_araddr got=%h exp=0", araddr); end
        total++; if (rready !== 1'b0) begin bad++; $display("FAIL reset_rready got=%b exp=0", rready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        total++; if (resp_last !== 1'b0) begin bad++; $display("FAIL reset_resp_last got=%b exp=0", resp_last); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_basic();
        resp_ready = 1'b1;
        req_addr   = 32'h0000_004C;
        req_valid  = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL basic_req_ready got=%b exp=1", req_ready); end
        total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL basic_arvalid_pre got=%b exp=0", arvalid); end
        cyc();
        req_valid = 1'b0;
        #1;
        total++; if (arvalid !== 1'b1) begin bad++; $display("FAIL basic_arvalid got=%b exp=1", arvalid); end
        total++; if (araddr !== 32'h0000_0040) begin bad++; $display("FAIL basic_araddr got=%h exp=00000040", araddr); end
        total++; if (arlen !== 8'd7) begin bad++; $display("FAIL basic_arlen got=%0d exp=7", arlen); end
        total++; if (arsize !== 3'd2) begin bad++; $display("FAIL basic_arsize got=%0d exp=2", arsize); end
        total++; if (arburst !== 2'd1) begin bad++; $display("FAIL basic_arburst got=%0d exp=1", arburst); end
        total++; if (arid !== 4'd0) begin bad++; $display("FAIL basic_arid got=%0d exp=0", arid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
        cyc();
        total++; if (arvalid !== 1'b1) begin bad++; $display("FAIL basic_arvalid_hold got=%b exp=1", arvalid); end
        cyc();
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        #1;
        total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL basic_arvalid_drop got=%b exp=0", arvalid); end
        for (int i = 0; i < 8; i++) begin
            drive_beat(32'hA000_0000 + i, (i == 7), 2'b00);
            #1;
            total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL basic_resp_valid beat%0d got=%b exp=1", i, resp_valid); end
            total++; if (resp_data !== 32'hA000_0000 + i) begin bad++; $display("FAIL basic_resp_data beat%0d got=%h exp=%h", i, resp_data, 32'hA000_0000 + i); end
            total++; if (resp_last !== (i == 7)) begin bad++; $display("FAIL basic_resp_last beat%0d got=%b exp=%b", i, resp_last, (i == 7)); end
            total++; if (rready !== 1'b1) begin bad++; $display("FAIL basic_rready beat%0d got=%b exp=1", i, rready); end
            cyc();
        end
        stop_beats();
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL basic_req_ready_end got=%b exp=1", req_ready); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", err); end
    endtask

    task automatic test_backpressure();
        int idx;
        int k;
        resp_ready = 1'b1;
        start_burst(32'h0000_0100, 0);
        idx = 0;
        k   = 0;
        // Slave holds each beat until taken; cache ready alternates 1,0,1,0,...
        while (k < 15) begin
            resp_ready = ((k % 2) == 0);
            drive_beat(32'hB000_0000 + idx, (idx == 7), 2'b00);
            #1;
            total++; if (rready !== resp_ready) begin bad++; $display("FAIL bp_rready cyc%0d got=%b exp=%b", k, rready, resp_ready); end
            total++; if (resp_valid !== 1'b1 || resp_data !== 32'hB000_0000 + idx) begin bad++; $display("FAIL bp_data cyc%0d got=%b/%h exp=1/%h", k, resp_valid, resp_data, 32'hB000_0000 + idx); end
            total++; if (resp_last !== (idx == 7)) begin bad++; $display("FAIL bp_last cyc%0d got=%b exp=%b", k, resp_last, (idx == 7)); end
            if (resp_ready) idx++;
            cyc();
            k++;
        end
        stop_beats();
        resp_ready = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_busy_end got=%b exp=0", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL bp_err got=%b exp=0", err); end
    endtask

    task automatic test_abort_addr();
        resp_ready = 1'b0;
        req_addr   = 32'h0000_0200;
        req_valid  = 1'b1;
        cyc();
        req_valid = 1'b0;
        abort     = 1'b1;
        #1;
        total++; if (arvalid !== 1'b1) begin bad++; $display("FAIL aa_arvalid got=%b exp=1", arvalid); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL aa_req_ready got=%b exp=0", req_ready); end
        cyc();
        abort = 1'b0;
        #1;
        total++; if (arvalid !== 1'b1) begin bad++; $display("FAIL aa_arvalid_held got=%b exp=1", arvalid); end
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        #1;
        total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL aa_arvalid_drop got=%b exp=0", arvalid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL aa_busy got=%b exp=1", busy); end
        for (int i = 0; i < 8; i++) begin
            drive_beat(32'hCC00_0000 + i, (i == 7), 2'b00);
            #1;
            total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL aa_resp_valid beat%0d got=%b exp=0", i, resp_valid); end
            total++; if (rready !== 1'b1) begin bad++; $display("FAIL aa_rready beat%0d got=%b exp=1", i, rready); end
            cyc();
        end
        stop_beats();
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL aa_busy_end got=%b exp=0", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL aa_err got=%b exp=0", err); end
    endtask

    task automatic test_abort_data();
        resp_ready = 1'b1;
        start_burst(32'h0000_0300, 0);
        for (int i = 0; i < 4; i++) begin
            drive_beat(32'hC000_0000 + i, 1'b0, 2'b00);
            #1;
            total++; if (resp_valid !== 1'b1 || resp_data !== 32'hC000_0000 + i) begin bad++; $display("FAIL ad_data beat%0d got=%b/%h exp=1/%h", i, resp_valid, resp_data, 32'hC000_0000 + i); end
            cyc();
        end
        drive_beat(32'hC000_0004, 1'b0, 2'b00);
        abort = 1'b1;
        #1;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL ad_abort_resp_valid got=%b exp=0", resp_valid); end
        total++; if (rready !== 1'b1) begin bad++; $display("FAIL ad_abort_rready got=%b exp=1", rready); end
        cyc();
        abort      = 1'b0;
        resp_ready = 1'b0;
        for (int i = 5; i < 8; i++) begin
            drive_beat(32'hC000_0000 + i, (i == 7), 2'b00);
            #1;
            total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL ad_drain_resp_valid beat%0d got=%b exp=0", i, resp_valid); end
            total++; if (rready !== 1'b1) begin bad++; $display("FAIL ad_drain_rready beat%0d got=%b exp=1", i, rready); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL ad_drain_busy beat%0d got=%b exp=1", i, busy); end
            cyc();
        end
        stop_beats();
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ad_busy_end got=%b exp=0", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL ad_err got=%b exp=0", err); end
        req_addr  = 32'h0000_0080;
        req_valid = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL ad_new_req_ready got=%b exp=1", req_ready); end
        cyc();
        req_valid = 1'b0;
        #1;
        total++; if (arvalid !== 1'b1 || araddr !== 32'h0000_0080) begin bad++; $display("FAIL ad_new_araddr got=%b/%h exp=1/00000080", arvalid, araddr); end
        arready = 1'b1;
        cyc();
        arready    = 1'b0;
        resp_ready = 1'b1;
        good_beats(0);
    endtask

    task automatic test_err_rresp();
        resp_ready = 1'b1;
        start_burst(32'h0000_0400, 0);
        for (int i = 0; i < 8; i++) begin
            drive_beat(32'hD000_0000 + i, (i == 7), (i == 2) ? 2'b10 : 2'b00);
            #1;
            if (i == 2) begin
                total++; if (err !== 1'b0) begin bad++; $display("FAIL er_err_before got=%b exp=0", err); end
            end
            if (i == 3) begin
                total++; if (err !== 1'b1) begin bad++; $display("FAIL er_err_after got=%b exp=1", err); end
            end
            cyc();
        end
        stop_beats();
        #1;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL er_err_idle got=%b exp=1", err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL er_busy_end got=%b exp=0", busy); end
        req_addr  = 32'h0000_0440;
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL er_err_cleared got=%b exp=0", err); end
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        good_beats(0);
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL er_err_clean_burst got=%b exp=0", err); end
    endtask

    task automatic test_early_rlast();
        resp_ready = 1'b1;
        start_burst(32'h0000_0500, 0);
        for (int i = 0; i < 6; i++) begin
            drive_beat(32'hE000_0000 + i, (i == 5), 2'b00);
            #1;
            total++; if (err !== 1'b0) begin bad++; $display("FAIL el_err_early beat%0d got=%b exp=0", i, err); end
            cyc();
        end
        stop_beats();
        #1;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL el_err got=%b exp=1", err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL el_busy got=%b exp=0", busy); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL el_req_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_reset_mid();
        resp_ready = 1'b1;
        start_burst(32'h0000_0600, 0);
        for (int i = 0; i < 4; i++) begin
            drive_beat(32'hF000_0000 + i, 1'b0, (i == 1) ? 2'b11 : 2'b00);
            cyc();
        end
        total++; if (err !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rm_pre got=%b/%b exp=1/1", err, busy); end
        drive_beat(32'hF000_0004, 1'b0, 2'b00);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        stop_beats();
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", busy); end
        total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL rm_arvalid got=%b exp=0", arvalid); end
        total++; if (araddr !== 32'h0) begin bad++; $display("FAIL rm_araddr got=%h exp=0", araddr); end
        total++; if (rready !== 1'b0) begin bad++; $display("FAIL rm_rready got=%b exp=0", rready); end
        total++; if (resp_valid !== 1'b0 || resp_last !== 1'b0) begin bad++; $display("FAIL rm_resp got=%b/%b exp=0/0", resp_valid, resp_last); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rm_err got=%b exp=0", err); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rm_req_ready got=%b exp=1", req_ready); end
    endtask

    initial begin
        rst        = 1'b1;
        req_addr   = 32'h0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        abort      = 1'b0;
        arready    = 1'b0;
        rid        = 4'd0;
        rdata      = 32'h0;
        rresp      = 2'b00;
        rlast      = 1'b0;
        rvalid     = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_abort_addr();
        test_abort_data();
        test_err_rresp();
        test_early_rlast();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
